// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder around one shared full adder
// Optional macro SERIAL_SUB_EN adds a latched op_sub that turns the operation into a-b.

module adder_1bit (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             b_bit, s_bit, c_bit;
    logic             carry_init;

`ifdef SERIAL_SUB_EN
    logic sub_q, sub_d;

    // Subtraction is a + ~b + 1: invert the serial b bit, seed the carry with 1.
    assign b_bit      = b_sr_q[0] ^ sub_q;
    assign carry_init = op_sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sub_q <= 1'b0;
        else        sub_q <= sub_d;
    end

    always_comb begin
        sub_d = sub_q;
        if (start && (state_q != S_RUN)) sub_d = op_sub;
    end
`else
    logic unused_op_sub;

    assign unused_op_sub = op_sub;
    assign b_bit         = b_sr_q[0];
    assign carry_init    = 1'b0;
`endif

    adder_1bit u_fa (
        .a_i (a_sr_q[0]),
        .b_i (b_bit),
        .c_i (carry_q),
        .s_o (s_bit),
        .c_o (c_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = {s_bit, res_sr_q[WIDTH-1:1]};
                carry_d  = c_bit;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // carry_q here is the carry into the MSB.
                    sum_d   = {s_bit, res_sr_q[WIDTH-1:1]};
                    cout_d  = c_bit;
                    ovf_d   = carry_q ^ c_bit;
                    state_d = S_DONE;
                end
            end
            default: begin
                if (state_q == S_DONE) state_d = S_IDLE;
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = carry_init;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
        endcase
    end

    assign ready = (state_q != S_RUN);
    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl (WIDTH=8)

module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op_sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready, busy, done, cout, ovf;
    logic [W-1:0] sum;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_err = 0;
    int           last_acc = 0;
    logic [W-1:0] last_sum = '0;
    logic         last_cout = 1'b0;
    logic         last_ovf = 1'b0;
    logic         prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        exp_t e;
        int   ua, ub, t;
        int   sa, sb_s, st;
        ua = int'(av);
        ub = int'(bv);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb_s = (ub >= 128) ? ub - 256 : ub;
        t  = ua + ub;
        st = sa + sb_s;
`ifdef SERIAL_SUB_EN
        if (sv) begin
            t  = ua + (255 - ub) + 1;
            st = sa - sb_s;
        end
`endif
        e.sum  = W'(t % 256);
        e.cout = (t >= 256);
        e.ovf  = (st > 127) || (st < -128);
        e.due  = 0;
        if (sv) e.due = 0;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                check("done_one_cycle", int'(prev_done), 0);
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sum", int'(sum), int'(e.sum));
                    check("cout", int'(cout), int'(e.cout));
                    check("ovf", int'(ovf), int'(e.ovf));
                    check("latency", cyc, e.due);
                    last_sum  = e.sum;
                    last_cout = e.cout;
                    last_ovf  = e.ovf;
                end
            end else begin
                check("result_held", int'({sum, cout, ovf}), int'({last_sum, last_cout, last_ovf}));
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv, input bit hold);
        int   n;
        exp_t e;
        @(negedge clk);
        a = av;
        b = bv;
        op_sub = sv;
        start = 1'b1;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            check("accept_timeout", 0, 1);
        end else begin
            e = model(av, bv, sv);
            e.due = cyc + 1 + W;
            sb.push_back(e);
            last_acc = cyc;
        end
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int nb, acc0;
        #12;
        check("rst_ready", int'(ready), 1);
        check("rst_busy_done", int'({busy, done}), 0);
        check("rst_result", int'({sum, cout, ovf}), 0);
        @(negedge clk);
        #3 rst_n = 1'b1;

        issue(8'h35, 8'h4A, 1'b0, 1'b0);
        nb = 0;
        repeat (W + 2) begin
            @(negedge clk);
            if (busy) nb++;
        end
        check("busy_cycles", nb, W);
        drain();

        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        issue(8'h7F, 8'h01, 1'b0, 1'b0);
        drain();

        issue(8'h35, 8'h4A, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'h11;
        b = 8'h22;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        issue(8'h12, 8'h34, 1'b0, 1'b1);
        acc0 = last_acc;
        issue(8'hC0, 8'h50, 1'b0, 1'b0);
        check("back_to_back_gap", last_acc - acc0, W + 1);
        drain();

        issue(8'hFF, 8'hFF, 1'b0, 1'b0);
        drain();
        issue(8'h5A, 8'h33, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_ready_busy_done", int'({ready, busy, done}), 3'b100);
        check("midrun_rst_result", int'({sum, cout, ovf}), 0);
        sb.delete();
        last_sum  = '0;
        last_cout = 1'b0;
        last_ovf  = 1'b0;
        @(negedge clk);
        #3 rst_n = 1'b1;
        issue(8'h01, 8'h02, 1'b0, 1'b0);
        drain();

        issue(8'h05, 8'h07, 1'b1, 1'b0);
        issue(8'h80, 8'h01, 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
